// File: rtl/fetch_line_controller.sv
// fetch_line_controller
//
// Instruction-fetch stage that fetches whole aligned lines of LINE_WORDS
// instructions with AXI4 INCR read bursts. The last line fetched is kept in a
// one-entry line buffer. Sequential and branch targets that fall inside the
// buffer are served without bus traffic. fence.i invalidates the buffer.
//
// Ports
//   clk, rst_n                   clock, asynchronous active-low reset
//   valid_pre_i / ready_pre_o    next-PC handshake from writeback
//   branch_en_i, dnpc_i          redirect to dnpc_i, otherwise PC+4
//   fence_i_i                    invalidate line buffer (with pre handshake)
//   valid_post_o / ready_post_i  instruction handshake to decode
//   pc_o, inst_o                 current PC and its instruction
//   ar*                          AXI4 read-address channel (master side)
//   r*                           AXI4 read-data channel (master side)
//   err_o                        sticky bus/protocol error
//   hit_cnt_o, miss_cnt_o        saturating line-buffer lookup counters
module fetch_line_controller #(
  parameter logic [31:0] RESET_VECTOR = 32'h8000_0000,
  parameter int          LINE_WORDS   = 4,
  parameter logic [3:0]  AXI_ID       = 4'h0,
  parameter int          CNT_WIDTH    = 32
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 valid_pre_i,
  output logic                 ready_pre_o,
  input  logic                 branch_en_i,
  input  logic [31:0]          dnpc_i,
  input  logic                 fence_i_i,
  output logic                 valid_post_o,
  input  logic                 ready_post_i,
  output logic [31:0]          pc_o,
  output logic [31:0]          inst_o,
  output logic                 arvalid_o,
  input  logic                 arready_i,
  output logic [31:0]          araddr_o,
  output logic [3:0]           arid_o,
  output logic [7:0]           arlen_o,
  output logic [2:0]           arsize_o,
  output logic [1:0]           arburst_o,
  input  logic                 rvalid_i,
  output logic                 rready_o,
  input  logic [1:0]           rresp_i,
  input  logic [31:0]          rdata_i,
  input  logic                 rlast_i,
  input  logic [3:0]           rid_i,
  output logic                 err_o,
  output logic [CNT_WIDTH-1:0] hit_cnt_o,
  output logic [CNT_WIDTH-1:0] miss_cnt_o
);

  localparam int OFF = $clog2(LINE_WORDS) + 2;
  // A single-word line still needs one counter bit.
  localparam int BW  = (LINE_WORDS == 1) ? 1 : OFF - 2;
  localparam int TW  = 32 - OFF;
  localparam logic [BW-1:0] LAST_BEAT = BW'(LINE_WORDS - 1);

  typedef enum logic [2:0] {
    INIT, IDLE, LOOKUP, WAIT_ARREADY, WAIT_RVALID, WAIT_READY, ERROR
  } state_t;

  state_t                state, state_next;
  logic [31:0]           pc;
  logic [31:0]           inst;
  logic                  line_valid;
  logic [TW-1:0]         tag;
  logic [31:0]           words [LINE_WORDS];
  logic [BW-1:0]         beat;
  logic                  err;
  logic [CNT_WIDTH-1:0]  hit_cnt, miss_cnt;

  logic [BW-1:0]         idx;
  logic                  hit;
  logic                  final_beat;
  logic                  beat_bad;

  assign idx        = (LINE_WORDS == 1) ? '0 : BW'(pc >> 2);
  assign hit        = line_valid && (pc[31:OFF] == tag);
  assign final_beat = (beat == LAST_BEAT);
  // rlast must appear on exactly the final beat, no earlier and no later.
  assign beat_bad   = (rresp_i != 2'b00) || (rid_i != AXI_ID) ||
                      (rlast_i != final_beat);

  assign pc_o       = pc;
  assign inst_o     = inst;
  assign err_o      = err;
  assign hit_cnt_o  = hit_cnt;
  assign miss_cnt_o = miss_cnt;

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values of the others regardless of block order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= INIT;
    else        state <= state_next;
  end

  // NOTE: every output and next-state variable gets a default first so no
  // path through the case statement leaves a latch behind.
  always_comb begin
    state_next   = state;
    ready_pre_o  = 1'b0;
    valid_post_o = 1'b0;
    arvalid_o    = 1'b0;
    araddr_o     = '0;
    arid_o       = '0;
    arlen_o      = '0;
    arsize_o     = '0;
    arburst_o    = '0;
    rready_o     = 1'b0;
    case (state)
      INIT:   state_next = LOOKUP;
      IDLE: begin
        ready_pre_o = 1'b1;
        if (valid_pre_i) state_next = LOOKUP;
      end
      LOOKUP: state_next = hit ? WAIT_READY : WAIT_ARREADY;
      WAIT_ARREADY: begin
        arvalid_o = 1'b1;
        araddr_o  = {pc[31:OFF], {OFF{1'b0}}};
        arid_o    = AXI_ID;
        arlen_o   = 8'(LINE_WORDS - 1);
        arsize_o  = 3'b010;
        arburst_o = 2'b01;
        if (arready_i) state_next = WAIT_RVALID;
      end
      WAIT_RVALID: begin
        rready_o = 1'b1;
        if (rvalid_i) begin
          if (beat_bad)        state_next = ERROR;
          else if (final_beat) state_next = WAIT_READY;
        end
      end
      WAIT_READY: begin
        valid_post_o = 1'b1;
        if (ready_post_i) state_next = IDLE;
      end
      ERROR:   state_next = ERROR;
      default: state_next = ERROR;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pc         <= RESET_VECTOR;
      inst       <= '0;
      line_valid <= 1'b0;
      tag        <= '0;
      beat       <= '0;
      err        <= 1'b0;
      hit_cnt    <= '0;
      miss_cnt   <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (valid_pre_i) begin
            pc <= branch_en_i ? dnpc_i : pc + 32'd4;
            if (fence_i_i) line_valid <= 1'b0;
          end
        end
        LOOKUP: begin
          if (hit) begin
            inst <= words[idx];
            if (hit_cnt != '1) hit_cnt <= hit_cnt + 1'b1;
          end else begin
            line_valid <= 1'b0;
            if (miss_cnt != '1) miss_cnt <= miss_cnt + 1'b1;
          end
        end
        WAIT_RVALID: begin
          if (rvalid_i) begin
            if (beat_bad) begin
              err <= 1'b1;
            end else if (final_beat) begin
              tag        <= pc[31:OFF];
              line_valid <= 1'b1;
              beat       <= '0;
              // The final word is still on rdata_i; earlier words are stored.
              inst       <= (idx == beat) ? rdata_i : words[idx];
            end else begin
              beat <= beat + BW'(1);
            end
          end
        end
        default: ;
      endcase
    end
  end

  // NOTE: the line storage has no reset; line_valid guards every read, so
  // resetting the data would only add logic.
  always_ff @(posedge clk) begin
    if (state == WAIT_RVALID && rvalid_i && !beat_bad) words[beat] <= rdata_i;
  end

endmodule
